// File: rtl/izh_pkg.sv
// Shared constants and types for the neuron timestep scheduler.
// Optional feature macro used by the scheduler: NEURON_SCHED_SPIKE_COUNT_EN.
package izh_pkg;

    localparam int NUMWIDTH   = 16;
    localparam int TAGBITS    = 6;
    localparam int NUMNEURONS = 2**TAGBITS;

    typedef logic [NUMWIDTH:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_ISSUE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/neuron_update_scheduler_if.sv
// Bundles timestep control, state-register and update-unit signals of the scheduler.
// master = scheduler side, slave = environment (control, state register, update unit).
interface neuron_update_scheduler_if #(
    parameter int NUMWIDTH = izh_pkg::NUMWIDTH,
    parameter int TAGBITS  = izh_pkg::TAGBITS
);
    logic                start;
    logic                busy;
    logic                done;

    logic                sreg_read_en;
    logic                sreg_write_en;
    logic [TAGBITS-1:0]  sreg_tag;
    logic [NUMWIDTH:0]   sreg_v;
    logic [NUMWIDTH:0]   sreg_u;
    logic [NUMWIDTH:0]   sreg_v_new;
    logic [NUMWIDTH:0]   sreg_u_new;

    logic                upd_valid;
    logic                upd_ready;
    logic [NUMWIDTH:0]   upd_v;
    logic [NUMWIDTH:0]   upd_u;

    logic                res_valid;
    logic                res_ready;
    logic [NUMWIDTH:0]   res_v;
    logic [NUMWIDTH:0]   res_u;
    logic                res_spike;

    logic                spike_valid;
    logic [TAGBITS-1:0]  spike_tag;
    logic [TAGBITS:0]    spike_count;

    modport master (
        input  start, sreg_v, sreg_u, upd_ready, res_valid, res_v, res_u, res_spike,
        output busy, done, sreg_read_en, sreg_write_en, sreg_tag, sreg_v_new, sreg_u_new,
               upd_valid, upd_v, upd_u, res_ready, spike_valid, spike_tag, spike_count
    );

    modport slave (
        output start, sreg_v, sreg_u, upd_ready, res_valid, res_v, res_u, res_spike,
        input  busy, done, sreg_read_en, sreg_write_en, sreg_tag, sreg_v_new, sreg_u_new,
               upd_valid, upd_v, upd_u, res_ready, spike_valid, spike_tag, spike_count
    );

endinterface

// File: rtl/neuron_update_scheduler_tag_counter.sv
// Neuron tag counter: one bit wider than the tag so the terminal compare can never wrap.
module sched_tag_counter #(
    parameter int TAGBITS    = izh_pkg::TAGBITS,
    parameter int NUMNEURONS = 2**TAGBITS
) (
    input  logic               clk,
    input  logic               asyn_reset,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [TAGBITS-1:0] tag_o,
    output logic               last_o
);
    localparam logic [TAGBITS:0] LAST_TAG = (TAGBITS+1)'(NUMNEURONS - 1);

    logic [TAGBITS:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST_TAG);
    assign tag_o  = cnt_q[TAGBITS-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + (TAGBITS+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Walks every neuron once per timestep: read v/u, hand to update unit, write result back.
// Optional spike counter enabled by defining NEURON_SCHED_SPIKE_COUNT_EN.
module neuron_update_scheduler #(
    parameter int NUMWIDTH   = izh_pkg::NUMWIDTH,
    parameter int TAGBITS    = izh_pkg::TAGBITS,
    parameter int NUMNEURONS = 2**TAGBITS
) (
    input  logic clk,
    input  logic asyn_reset,
    neuron_update_scheduler_if.master bus
);
    import izh_pkg::*;

    // state     | meaning
    // IDLE      | wait for start; READ/WAIT/LOAD fetch v/u of current tag
    // ISSUE     | operands offered to update unit; COLLECT waits for result
    // WRITE     | write back + spike strobe; DONE one-cycle end-of-timestep pulse

    sched_state_e state_q, state_d;

    logic [NUMWIDTH:0] upd_v_q, upd_u_q;
    logic [NUMWIDTH:0] res_v_q, res_u_q;
    logic              res_spike_q;

    logic               tag_clr, tag_inc, tag_last;
    logic [TAGBITS-1:0] tag;

    logic busy_c, done_c, read_en_c, write_en_c, upd_valid_c, res_ready_c, spike_valid_c;

    sched_tag_counter #(
        .TAGBITS    (TAGBITS),
        .NUMNEURONS (NUMNEURONS)
    ) u_tag_counter (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .clr_i      (tag_clr),
        .inc_i      (tag_inc),
        .tag_o      (tag),
        .last_o     (tag_last)
    );

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tag_clr       = 1'b0;
        tag_inc       = 1'b0;
        busy_c        = 1'b1;
        done_c        = 1'b0;
        read_en_c     = 1'b0;
        write_en_c    = 1'b0;
        upd_valid_c   = 1'b0;
        res_ready_c   = 1'b0;
        spike_valid_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    tag_clr = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_en_c = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: begin
                upd_valid_c = 1'b1;
                if (bus.upd_ready) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                res_ready_c = 1'b1;
                if (bus.res_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                write_en_c    = 1'b1;
                spike_valid_c = res_spike_q;
                if (tag_last) begin
                    state_d = S_DONE;
                end else begin
                    tag_inc = 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands are loaded only in LOAD, so they stay frozen for the whole ISSUE phase.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            upd_v_q     <= '0;
            upd_u_q     <= '0;
            res_v_q     <= '0;
            res_u_q     <= '0;
            res_spike_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                upd_v_q <= bus.sreg_v;
                upd_u_q <= bus.sreg_u;
            end
            if (state_q == S_COLLECT && bus.res_valid) begin
                res_v_q     <= bus.res_v;
                res_u_q     <= bus.res_u;
                res_spike_q <= bus.res_spike;
            end
        end
    end

`ifdef NEURON_SCHED_SPIKE_COUNT_EN
    logic [TAGBITS:0] spike_cnt_q, spike_cnt_d;

    always_comb begin
        spike_cnt_d = spike_cnt_q;
        if (tag_clr) begin
            spike_cnt_d = '0;
        end else if (write_en_c && res_spike_q) begin
            spike_cnt_d = spike_cnt_q + (TAGBITS+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            spike_cnt_q <= '0;
        end else begin
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign bus.spike_count = spike_cnt_q;
`else
    assign bus.spike_count = '0;
`endif

    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.sreg_read_en  = read_en_c;
    assign bus.sreg_write_en = write_en_c;
    assign bus.sreg_tag      = tag;
    assign bus.sreg_v_new    = res_v_q;
    assign bus.sreg_u_new    = res_u_q;
    assign bus.upd_valid     = upd_valid_c;
    assign bus.upd_v         = upd_v_q;
    assign bus.upd_u         = upd_u_q;
    assign bus.res_ready     = res_ready_c;
    assign bus.spike_valid   = spike_valid_c;
    assign bus.spike_tag     = tag;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench: behavioural state register + update unit around the scheduler, NUMNEURONS=4.
module tb_neuron_update_scheduler;
    localparam int NW = 16;
    localparam int TB = 2;
    localparam int NN = 4;
    typedef logic [NW:0] w_t;

    logic clk = 1'b0;
    logic asyn_reset;
    always #5 clk = ~clk;

    neuron_update_scheduler_if #(.NUMWIDTH(NW), .TAGBITS(TB)) bus();

    neuron_update_scheduler #(.NUMWIDTH(NW), .TAGBITS(TB)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus)
    );

    int checks = 0;
    int passed = 0;

    w_t mem_v[NN], mem_u[NN], snap_v[NN], snap_u[NN];
    int icfg[NN], rcfg[NN];
    bit mask[NN];

    int  istall, rstall, nidx;
    bit  pending;
    w_t  op_v, op_u;

    int busy_cyc, done_cnt, overlap, opnd_err, uv_cyc, rr_cyc;
    int wr_tag[$];
    w_t wr_v[$], wr_u[$];
    int sp_tag[$];

    // Behavioural state register and update unit; result is v+1, u unchanged.
    always @(negedge clk) begin
        if (asyn_reset) begin
            pending       = 1'b0;
            istall        = 0;
            rstall        = 0;
            nidx          = 0;
            bus.upd_ready = 1'b0;
            bus.res_valid = 1'b0;
        end else begin
            if (bus.busy) busy_cyc++;
            if (bus.sreg_read_en && bus.sreg_write_en) overlap++;
            if (bus.upd_valid) uv_cyc++;
            if (bus.res_ready) rr_cyc++;
            if (bus.spike_valid) sp_tag.push_back(int'(bus.spike_tag));
            if (bus.sreg_write_en) begin
                wr_tag.push_back(int'(bus.sreg_tag));
                wr_v.push_back(bus.sreg_v_new);
                wr_u.push_back(bus.sreg_u_new);
                mem_v[bus.sreg_tag] = bus.sreg_v_new;
                mem_u[bus.sreg_tag] = bus.sreg_u_new;
            end
            if (bus.sreg_read_en) begin
                bus.sreg_v = mem_v[bus.sreg_tag];
                bus.sreg_u = mem_u[bus.sreg_tag];
                istall = (nidx < NN) ? icfg[nidx] : 0;
            end
            if (bus.upd_valid) begin
                if (nidx >= NN || bus.upd_v !== mem_v[nidx] || bus.upd_u !== mem_u[nidx]) opnd_err++;
                if (istall > 0) begin
                    bus.upd_ready = 1'b0;
                    istall--;
                end else begin
                    bus.upd_ready = 1'b1;
                    op_v    = bus.upd_v;
                    op_u    = bus.upd_u;
                    pending = 1'b1;
                    rstall  = (nidx < NN) ? rcfg[nidx] : 0;
                end
            end else begin
                bus.upd_ready = 1'b0;
            end
            if (bus.res_ready && pending) begin
                if (rstall > 0) begin
                    bus.res_valid = 1'b0;
                    rstall--;
                end else begin
                    bus.res_valid = 1'b1;
                    bus.res_v     = w_t'(op_v + 1);
                    bus.res_u     = op_u;
                    bus.res_spike = (nidx < NN) ? mask[nidx] : 1'b0;
                    pending       = 1'b0;
                    nidx++;
                end
            end else begin
                bus.res_valid = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                nidx = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        busy_cyc = 0; done_cnt = 0; overlap = 0; opnd_err = 0; uv_cyc = 0; rr_cyc = 0;
        wr_tag.delete(); wr_v.delete(); wr_u.delete(); sp_tag.delete();
        nidx = 0;
    endtask

    task automatic setup(input bit rand_mem);
        for (int i = 0; i < NN; i++) begin
            if (rand_mem) begin
                mem_v[i] = w_t'($urandom);
                mem_u[i] = w_t'($urandom);
            end
            icfg[i] = 0;
            rcfg[i] = 0;
            mask[i] = 1'b0;
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < NN; i++) begin
            snap_v[i] = mem_v[i];
            snap_u[i] = mem_u[i];
        end
    endtask

    task automatic run_ts(input int glitch, output bit to);
        clear_obs();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        to = 1'b1;
        for (int c = 1; c < 3000; c++) begin
            bus.start = (glitch > 0 && (c == glitch || c == glitch + 10)) ? 1'b1 : 1'b0;
            tick();
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        asyn_reset = 1'b1;
        bus.start  = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {bus.busy, bus.done});
        else passed++;
        checks++;
        if ({bus.sreg_read_en, bus.sreg_write_en, bus.upd_valid, bus.res_ready, bus.spike_valid} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.sreg_read_en, bus.sreg_write_en, bus.upd_valid, bus.res_ready, bus.spike_valid});
        else passed++;
        checks++;
        if (bus.sreg_tag !== '0) $display("FAIL reset_sreg_tag: got %0d want 0", bus.sreg_tag);
        else passed++;
        checks++;
        if ({bus.upd_v, bus.upd_u, bus.sreg_v_new, bus.sreg_u_new} !== '0)
            $display("FAIL reset_data: got %h %h %h %h want 0", bus.upd_v, bus.upd_u, bus.sreg_v_new, bus.sreg_u_new);
        else passed++;
        checks++;
        if (bus.spike_count !== '0) $display("FAIL reset_spike_count: got %0d want 0", bus.spike_count);
        else passed++;
        asyn_reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        setup(1'b1);
        snapshot();
        run_ts(0, to);
        checks++;
        if (to) $display("FAIL basic_timeout: got no done want done");
        else passed++;
        checks++;
        if (wr_tag.size() != NN) $display("FAIL basic_write_count: got %0d want %0d", wr_tag.size(), NN);
        else passed++;
        for (int i = 0; i < NN && i < wr_tag.size(); i++) begin
            checks++;
            if (wr_tag[i] != i || wr_v[i] !== w_t'(snap_v[i] + 1) || wr_u[i] !== snap_u[i])
                $display("FAIL basic_write%0d: got tag %0d v %h u %h want tag %0d v %h u %h",
                         i, wr_tag[i], wr_v[i], wr_u[i], i, w_t'(snap_v[i] + 1), snap_u[i]);
            else passed++;
        end
        checks++;
        if (busy_cyc != 6 * NN + 1) $display("FAIL basic_cycles: got %0d want %0d", busy_cyc, 6 * NN + 1);
        else passed++;
        checks++;
        if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt);
        else passed++;
        checks++;
        if (overlap != 0 || opnd_err != 0) $display("FAIL basic_rw_operands: got %0d/%0d want 0/0", overlap, opnd_err);
        else passed++;
    endtask

    task automatic test_preload();
        bit to;
        setup(1'b1);
        mem_v[2] = 17'h1E000;
        mem_u[2] = 17'h00100;
        run_ts(0, to);
        checks++;
        if (to || wr_tag.size() != NN) $display("FAIL preload_run: got %0d writes want %0d", wr_tag.size(), NN);
        else passed++;
        checks++;
        if (wr_tag.size() > 2 && (wr_tag[2] != 2 || wr_v[2] !== 17'h1E001 || wr_u[2] !== 17'h00100))
            $display("FAIL preload_tag2: got tag %0d v %h u %h want tag 2 v 1e001 u 00100", wr_tag[2], wr_v[2], wr_u[2]);
        else passed++;
        checks++;
        if (opnd_err != 0) $display("FAIL preload_operands: got %0d bad operand cycles want 0", opnd_err);
        else passed++;
    endtask

    task automatic test_stall();
        bit to;
        setup(1'b1);
        icfg[1] = 3;
        rcfg[1] = 2;
        run_ts(0, to);
        checks++;
        if (to || busy_cyc != 6 * NN + 1 + 5) $display("FAIL stall_cycles: got %0d want %0d", busy_cyc, 6 * NN + 6);
        else passed++;
        checks++;
        if (wr_tag.size() != NN) $display("FAIL stall_write_count: got %0d want %0d", wr_tag.size(), NN);
        else passed++;
        checks++;
        if (uv_cyc != NN + 3 || rr_cyc != NN + 2)
            $display("FAIL stall_handshake_cycles: got %0d/%0d want %0d/%0d", uv_cyc, rr_cyc, NN + 3, NN + 2);
        else passed++;
        checks++;
        if (opnd_err != 0) $display("FAIL stall_operands_held: got %0d bad cycles want 0", opnd_err);
        else passed++;
    endtask

    task automatic test_spike();
        bit to;
        int exp_cnt;
        setup(1'b1);
        mask[0] = 1'b1;
        mask[3] = 1'b1;
        run_ts(0, to);
        checks++;
        if (to || sp_tag.size() != 2) $display("FAIL spike_pulses: got %0d want 2", sp_tag.size());
        else passed++;
        checks++;
        if (sp_tag.size() == 2 && (sp_tag[0] != 0 || sp_tag[1] != 3))
            $display("FAIL spike_tags: got %0d,%0d want 0,3", sp_tag[0], sp_tag[1]);
        else passed++;
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        checks++;
        if (int'(bus.spike_count) != exp_cnt) $display("FAIL spike_count: got %0d want %0d", bus.spike_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        setup(1'b1);
        rcfg[2] = 50;
        snapshot();
        clear_obs();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (nidx == 2 && bus.res_ready) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) $display("FAIL midreset_reach_collect: got no COLLECT for tag 2 want COLLECT");
        else passed++;
        asyn_reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.res_ready, bus.sreg_write_en, bus.done} !== 4'b0 || bus.sreg_tag !== '0)
            $display("FAIL midreset_immediate: got %b tag %0d want 0000 tag 0",
                     {bus.busy, bus.res_ready, bus.sreg_write_en, bus.done}, bus.sreg_tag);
        else passed++;
        tick();
        tick();
        tick();
        asyn_reset = 1'b0;
        tick();
        checks++;
        if (done_cnt != 0 || wr_tag.size() != 2 || mem_v[2] !== snap_v[2])
            $display("FAIL midreset_no_write: got done %0d writes %0d v2 %h want 0 2 %h",
                     done_cnt, wr_tag.size(), mem_v[2], snap_v[2]);
        else passed++;
        rcfg[2] = 0;
        run_ts(0, to);
        checks++;
        if (to || wr_tag.size() != NN || wr_tag[0] != 0 || done_cnt != 1)
            $display("FAIL midreset_restart: got %0d writes first tag %0d done %0d want %0d 0 1",
                     wr_tag.size(), (wr_tag.size() > 0) ? wr_tag[0] : -1, done_cnt, NN);
        else passed++;
    endtask

    task automatic test_start_busy();
        bit to;
        setup(1'b1);
        run_ts(8, to);
        checks++;
        if (to || done_cnt != 1) $display("FAIL startbusy_done_count: got %0d want 1", done_cnt);
        else passed++;
        checks++;
        if (busy_cyc != 6 * NN + 1 || wr_tag.size() != NN)
            $display("FAIL startbusy_length: got %0d cycles %0d writes want %0d %0d",
                     busy_cyc, wr_tag.size(), 6 * NN + 1, NN);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        setup(1'b1);
        snapshot();
        clear_obs();
        bus.start = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (done_cnt == 1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || bus.busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy %b want 0", bus.busy);
        else passed++;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_restart: got busy %b want 1", bus.busy);
        else passed++;
        for (int c = 0; c < 500 && done_cnt < 2; c++) tick();
        tick();
        tick();
        checks++;
        if (done_cnt != 2 || busy_cyc != 2 * (6 * NN + 1) || wr_tag.size() != 2 * NN)
            $display("FAIL b2b_totals: got done %0d cycles %0d writes %0d want 2 %0d %0d",
                     done_cnt, busy_cyc, wr_tag.size(), 2 * (6 * NN + 1), 2 * NN);
        else passed++;
        for (int i = 0; i < NN && NN + i < wr_v.size(); i++) begin
            checks++;
            if (wr_v[NN + i] !== w_t'(snap_v[i] + 2))
                $display("FAIL b2b_second_v%0d: got %h want %h", i, wr_v[NN + i], w_t'(snap_v[i] + 2));
            else passed++;
        end
    endtask

    task automatic test_random();
        bit to;
        int exp_cyc, exp_cnt;
        int exp_sp[$];
        for (int r = 0; r < 4; r++) begin
            setup(1'b1);
            exp_cyc = 6 * NN + 1;
            exp_sp.delete();
            for (int i = 0; i < NN; i++) begin
                icfg[i] = $urandom_range(0, 3);
                rcfg[i] = $urandom_range(0, 3);
                mask[i] = 1'($urandom_range(0, 1));
                exp_cyc += icfg[i] + rcfg[i];
                if (mask[i]) exp_sp.push_back(i);
            end
`ifdef NEURON_SCHED_SPIKE_COUNT_EN
            exp_cnt = exp_sp.size();
`else
            exp_cnt = 0;
`endif
            snapshot();
            run_ts(0, to);
            checks++;
            if (to || busy_cyc != exp_cyc) $display("FAIL rand%0d_cycles: got %0d want %0d", r, busy_cyc, exp_cyc);
            else passed++;
            checks++;
            if (wr_tag.size() != NN) $display("FAIL rand%0d_writes: got %0d want %0d", r, wr_tag.size(), NN);
            else passed++;
            for (int i = 0; i < NN && i < wr_tag.size(); i++) begin
                checks++;
                if (wr_tag[i] != i || wr_v[i] !== w_t'(snap_v[i] + 1) || wr_u[i] !== snap_u[i])
                    $display("FAIL rand%0d_write%0d: got tag %0d v %h u %h want v %h u %h",
                             r, i, wr_tag[i], wr_v[i], wr_u[i], w_t'(snap_v[i] + 1), snap_u[i]);
                else passed++;
            end
            checks++;
            if (sp_tag != exp_sp) $display("FAIL rand%0d_spikes: got %p want %p", r, sp_tag, exp_sp);
            else passed++;
            checks++;
            if (int'(bus.spike_count) != exp_cnt)
                $display("FAIL rand%0d_spike_count: got %0d want %0d", r, bus.spike_count, exp_cnt);
            else passed++;
            checks++;
            if (overlap != 0 || opnd_err != 0)
                $display("FAIL rand%0d_rw_operands: got %0d/%0d want 0/0", r, overlap, opnd_err);
            else passed++;
        end
    endtask

    initial begin
        asyn_reset    = 1'b1;
        bus.start     = 1'b0;
        bus.sreg_v    = '0;
        bus.sreg_u    = '0;
        bus.res_v     = '0;
        bus.res_u     = '0;
        bus.res_spike = 1'b0;
        bus.upd_ready = 1'b0;
        bus.res_valid = 1'b0;
        for (int i = 0; i < NN; i++) begin
            mem_v[i] = '0;
            mem_u[i] = '0;
        end
        test_reset();
        test_basic();
        test_preload();
        test_stall();
        test_spike();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/neuron_update_scheduler.md
# neuron_update_scheduler

Sequences one simulation timestep over all neurons held in the v/u state register. For each tag it reads v/u, hands them to the Izhikevich update unit over a valid/ready handshake, collects the new v/u and spike flag, and writes them back. It sits between the top-level timestep control (start/done) and the state register / update unit pair.

## Interface
- NUMWIDTH, 16: value MSB index; all v/u buses are NUMWIDTH+1 bits (1 sign + 8 int + 8 frac)
- TAGBITS, 6: neuron tag width
- NUMNEURONS, 2**TAGBITS: neurons per timestep (power of two)

- clk  in  1  single clock, rising edge
- asyn_reset  in  1  asynchronous, active-high reset
- start  in  1  begin timestep (sampled in IDLE only)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of timestep
- sreg_read_en  out  1  state register read enable
- sreg_write_en  out  1  state register write enable
- sreg_tag  out  TAGBITS  state register address
- sreg_v, sreg_u  in  NUMWIDTH+1  state register read data
- sreg_v_new, sreg_u_new  out  NUMWIDTH+1  write-back data
- upd_valid  out  1  operands valid to update unit
- upd_ready  in  1  update unit accepts operands
- upd_v, upd_u  out  NUMWIDTH+1  operands (registered)
- res_valid  in  1  update unit result valid
- res_ready  out  1  scheduler accepts result
- res_v, res_u  in  NUMWIDTH+1  updated state
- res_spike  in  1  neuron fired
- spike_valid  out  1  one-cycle pulse, neuron spiked
- spike_tag  out  TAGBITS  tag of spiking neuron
- spike_count  out  TAGBITS+1  spikes this timestep (see Configuration)

## Operation
- FSM states: IDLE, READ, WAIT, LOAD, ISSUE, COLLECT, WRITE, DONE.
- IDLE: start=1 -> tag counter cleared to 0, go READ. Otherwise stay.
- READ: sreg_read_en=1, sreg_tag=tag counter; -> WAIT.
- WAIT: no strobes; state register presents data at end of cycle; -> LOAD.
- LOAD: capture sreg_v/sreg_u into upd_v/upd_u registers; -> ISSUE.
- ISSUE: upd_valid=1; leave to COLLECT on the cycle upd_valid&&upd_ready.
- COLLECT: res_ready=1; on res_valid capture res_v/res_u/res_spike into result registers; -> WRITE.
- WRITE: sreg_write_en=1, sreg_tag=tag counter, sreg_v_new/u_new=captured result; spike_valid=captured spike, spike_tag=tag counter. If tag counter==NUMNEURONS-1 -> DONE, else increment -> READ.
- DONE: done=1 for one cycle; -> IDLE.
- Exactly one neuron in flight; read and write never target the state register in the same cycle.
- start while busy is ignored; start held high across DONE->IDLE starts the next timestep on the IDLE cycle.
- Tag counter is TAGBITS+1 wide internally; terminal compare prevents wrap; sreg_tag is its low TAGBITS bits.
- No arithmetic on v/u: data passed through unmodified, full width.

## Timing
- Reset values: busy=0, done=0, all strobes 0, sreg_tag=0, all data outputs 0, spike_count=0, FSM=IDLE.
- Reset mid-timestep: immediate return to IDLE, no write issued, no done.
- Per-neuron minimum 6 cycles (READ..WRITE) with upd_ready and res_valid high on first opportunity; each stall cycle adds one.
- Timestep minimum: 6*NUMNEURONS + 1 cycles from start sample to done pulse.
- upd_v/upd_u stable while upd_valid high; res_ready high only in COLLECT.

## Configuration
- NEURON_SCHED_SPIKE_COUNT_EN defined: spike_count cleared on accepted start, incremented in each WRITE cycle with spike_valid=1, holds through DONE and IDLE until next start.
- Undefined: spike_count tied to 0; no counter logic. All other behaviour identical.

## Structure
- Shared package izh_pkg: NUMWIDTH, TAGBITS, NUMNEURONS constants, FSM state typedef/localparams, v/u word type.
- One sub-module: sched_tag_counter (clear, increment, terminal flag); spike counter inline.

## Test plan
- Reset then start, NUMNEURONS=4, upd_ready=res_valid=1 -> writes to tags 0,1,2,3 in order, done exactly 25 cycles after start sampled.
- Preload tag 2 with v=0x1E000,u=0x00100, update unit returns v+1 -> tag 2 written with v=0x1E001, u=0x00100; upd_v equals preloaded value.
- upd_ready low 3 cycles, res_valid low 2 cycles for tag 1 -> upd_valid/operands held, timestep lengthens by exactly 5 cycles, no extra writes.
- res_spike=1 for tags 0 and 3 -> spike_valid pulses with spike_tag 0 then 3; with NEURON_SCHED_SPIKE_COUNT_EN spike_count=2 at done, else 0.
- asyn_reset asserted during COLLECT of tag 2 -> outputs reset immediately, no write to tag 2, no done; next start restarts from tag 0.
- start pulsed while busy -> ignored; only one done per timestep.
